// File: rtl/uart_tx_cfg_if.sv
// Write-side handshake of the configurable UART transmitter: one word per
// accepted valid/ready cycle.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] inputData;
    logic                 dataValid;
    logic                 dataReady;

    modport master (output inputData, output dataValid, input dataReady);
    modport slave  (input inputData, input dataValid, output dataReady);
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small word FIFO, configurable data width, parity and
// stop bits. The line advances one bit per clkEn tick.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstN,
    input  logic                            clkEn,
    uart_tx_cfg_if.slave                    wrIf,
    output logic                            serialOutput,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifoCount
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wrPtr, rdPtr;
    logic [DATA_BITS-1:0] shiftReg;
    logic [BW-1:0]        bitCnt;
    logic                 stopCnt;
    logic                 parBit;
    logic                 push, pop, fifoNonEmpty, lastStop, lastData, headPar;
    logic [DATA_BITS-1:0] headWord;

    assign fifoNonEmpty   = (fifoCount != '0);
    assign wrIf.dataReady = (fifoCount != CW'(FIFO_DEPTH));
    assign push           = wrIf.dataValid && wrIf.dataReady;
    assign headWord       = mem[rdPtr];
    assign headPar        = (PARITY == 1) ? ~^headWord : ^headWord;
    assign lastStop       = (int'(stopCnt) == STOP_BITS - 1);
    assign lastData       = (bitCnt == BW'(DATA_BITS - 1));
    // A frame only ever starts from IDLE or from the final stop period.
    assign pop = clkEn && fifoNonEmpty &&
                 ((state == IDLE) || (state == STOP && lastStop));

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= wrIf.inputData;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            serialOutput <= 1'b1;
            busy         <= 1'b0;
            shiftReg     <= '0;
            bitCnt       <= '0;
            stopCnt      <= 1'b0;
            parBit       <= 1'b0;
        end else if (clkEn) begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shiftReg     <= headWord;
                        parBit       <= headPar;
                        serialOutput <= 1'b0;
                        busy         <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    serialOutput <= shiftReg[0];
                    shiftReg     <= shiftReg >> 1;
                    bitCnt       <= '0;
                    state        <= DATA;
                end
                DATA: begin
                    if (!lastData) begin
                        serialOutput <= shiftReg[0];
                        shiftReg     <= shiftReg >> 1;
                        bitCnt       <= bitCnt + 1'b1;
                    end else if (PARITY != 0) begin
                        serialOutput <= parBit;
                        state        <= PAR;
                    end else begin
                        serialOutput <= 1'b1;
                        stopCnt      <= 1'b0;
                        state        <= STOP;
                    end
                end
                PAR: begin
                    serialOutput <= 1'b1;
                    stopCnt      <= 1'b0;
                    state        <= STOP;
                end
                STOP: begin
                    if (!lastStop) begin
                        stopCnt <= 1'b1;
                    end else if (pop) begin
                        // Next start bit follows the stop bit with no idle gap.
                        shiftReg     <= headWord;
                        parBit       <= headPar;
                        serialOutput <= 1'b0;
                        state        <= START;
                    end else begin
                        serialOutput <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    serialOutput <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8N1 default instance plus 8E1 and 7O2 variants.
module tb_uart_tx_cfg;
    logic clk, rstN, clkEn;
    logic ser0, ser1, ser2, busy0, busy1, busy2;
    logic [2:0] cnt0, cnt1, cnt2;
    int checks = 0;
    int errors = 0;

    uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_tx_cfg_if #(.DATA_BITS(7)) if2 ();

    uart_tx_cfg dut0 (.clk(clk), .rstN(rstN), .clkEn(clkEn), .wrIf(if0),
                      .serialOutput(ser0), .busy(busy0), .fifoCount(cnt0));
    uart_tx_cfg #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rstN(rstN), .clkEn(clkEn), .wrIf(if1),
        .serialOutput(ser1), .busy(busy1), .fifoCount(cnt1));
    uart_tx_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rstN(rstN), .clkEn(clkEn), .wrIf(if2),
        .serialOutput(ser2), .busy(busy2), .fifoCount(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick(input int gap);
        repeat (gap - 1) @(negedge clk);
        clkEn = 1'b1;
        @(negedge clk);
        clkEn = 1'b0;
    endtask

    task automatic write0(input logic [7:0] d);
        if0.inputData = d; if0.dataValid = 1'b1;
        @(negedge clk);
        if0.dataValid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (ser0 !== 1'b1) begin errors++; $display("FAIL rst_ser0 got %b exp 1", ser0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy0 got %b exp 0", busy0); end
        checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL rst_cnt0 got %0d exp 0", cnt0); end
        checks++; if (if0.dataReady !== 1'b1) begin errors++; $display("FAIL rst_ready0 got %b exp 1", if0.dataReady); end
        checks++; if ({ser1, ser2, busy1, busy2} !== 4'b1100) begin errors++; $display("FAIL rst_dut12 got %b exp 1100", {ser1, ser2, busy1, busy2}); end
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(4);
            checks++;
            if (ser0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++; $display("FAIL idle_empty tick %0d got ser=%b busy=%b exp ser=1 busy=0", i, ser0, busy0);
            end
        end
    endtask

    task automatic test_frame_8n1;
        logic e [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        write0(8'hA5);
        checks++; if (cnt0 !== 3'd1 || busy0 !== 1'b0 || ser0 !== 1'b1) begin
            errors++; $display("FAIL a5_queued got cnt=%0d busy=%b ser=%b exp 1 0 1", cnt0, busy0, ser0);
        end
        for (int i = 0; i < 10; i++) begin
            tick(16);
            checks++;
            if (ser0 !== e[i] || busy0 !== 1'b1) begin
                errors++; $display("FAIL a5_bit %0d got ser=%b busy=%b exp ser=%b busy=1", i, ser0, busy0, e[i]);
            end
            if (i == 0) begin
                checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL a5_pop got cnt=%0d exp 0", cnt0); end
            end
        end
        tick(16);
        checks++; if (ser0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL a5_end got ser=%b busy=%b exp 1 0", ser0, busy0);
        end
    endtask

    task automatic test_parity;
        logic e1 [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic e2 [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        if1.inputData = 8'h07; if1.dataValid = 1'b1;
        if2.inputData = 7'h55; if2.dataValid = 1'b1;
        @(negedge clk);
        if1.dataValid = 1'b0; if2.dataValid = 1'b0;
        // back-to-back clkEn cycles
        for (int i = 0; i < 12; i++) begin
            tick(1);
            checks++;
            if (ser1 !== e1[i] || busy1 !== (i < 11)) begin
                errors++; $display("FAIL even_bit %0d got ser=%b busy=%b exp ser=%b busy=%b", i, ser1, busy1, e1[i], i < 11);
            end
            checks++;
            if (ser2 !== e2[i] || busy2 !== (i < 11)) begin
                errors++; $display("FAIL odd7_bit %0d got ser=%b busy=%b exp ser=%b busy=%b", i, ser2, busy2, e2[i], i < 11);
            end
        end
    endtask

    task automatic test_fifo_full;
        logic [7:0] w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
        logic eb;
        for (int i = 0; i < 5; i++) begin
            write0(w[i]);
            checks++;
            if (cnt0 !== ((i < 4) ? 3'(i + 1) : 3'd4) || if0.dataReady !== (i < 3)) begin
                errors++; $display("FAIL full_wr %0d got cnt=%0d rdy=%b exp cnt=%0d rdy=%b", i, cnt0, if0.dataReady, (i < 4) ? i + 1 : 4, i < 3);
            end
        end
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 10; b++) begin
                tick(4);
                eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[f][b-1];
                checks++;
                if (ser0 !== eb || busy0 !== 1'b1) begin
                    errors++; $display("FAIL full_frame %0d bit %0d got ser=%b busy=%b exp ser=%b busy=1", f, b, ser0, busy0, eb);
                end
                if (b == 0) begin
                    checks++; if (cnt0 !== 3'(3 - f)) begin errors++; $display("FAIL full_cnt %0d got %0d exp %0d", f, cnt0, 3 - f); end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick(4);
            checks++;
            if (ser0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0) begin
                errors++; $display("FAIL full_drop %0d got ser=%b busy=%b cnt=%0d exp 1 0 0", i, ser0, busy0, cnt0);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w [3] = '{8'h3C, 8'h5A, 8'hC3};
        logic eb;
        write0(w[0]);
        write0(w[1]);
        checks++; if (cnt0 !== 3'd2) begin errors++; $display("FAIL b2b_pre got %0d exp 2", cnt0); end
        // push of the third word on the same edge the first word is popped
        if0.inputData = w[2]; if0.dataValid = 1'b1; clkEn = 1'b1;
        @(negedge clk);
        if0.dataValid = 1'b0; clkEn = 1'b0;
        checks++; if (cnt0 !== 3'd2 || ser0 !== 1'b0 || busy0 !== 1'b1) begin
            errors++; $display("FAIL b2b_pushpop got cnt=%0d ser=%b busy=%b exp 2 0 1", cnt0, ser0, busy0);
        end
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 10; b++) begin
                if (f != 0 || b != 0) begin
                    tick(4);
                    eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[f][b-1];
                    checks++;
                    if (ser0 !== eb || busy0 !== 1'b1) begin
                        errors++; $display("FAIL b2b_frame %0d bit %0d got ser=%b busy=%b exp ser=%b busy=1", f, b, ser0, busy0, eb);
                    end
                    if (b == 0) begin
                        checks++; if (cnt0 !== 3'(2 - f)) begin errors++; $display("FAIL b2b_cnt %0d got %0d exp %0d", f, cnt0, 2 - f); end
                    end
                end
            end
        end
        tick(4);
        checks++; if (ser0 !== 1'b1 || busy0 !== 1'b0) begin
            errors++; $display("FAIL b2b_end got ser=%b busy=%b exp 1 0", ser0, busy0);
        end
    endtask

    task automatic test_midframe_reset;
        logic e [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        if0.inputData = 8'h81; if0.dataValid = 1'b1; clkEn = 1'b1;
        @(negedge clk);
        if0.dataValid = 1'b0; clkEn = 1'b0;
        checks++; if (ser0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd1) begin
            errors++; $display("FAIL same_edge got ser=%b busy=%b cnt=%0d exp 1 0 1", ser0, busy0, cnt0);
        end
        for (int i = 0; i < 5; i++) begin
            tick(4);
            checks++;
            if (ser0 !== e[i] || busy0 !== 1'b1) begin
                errors++; $display("FAIL rstf_bit %0d got ser=%b busy=%b exp ser=%b busy=1", i, ser0, busy0, e[i]);
            end
            if (i == 0) begin
                write0(8'h12);
                write0(8'h34);
                checks++; if (cnt0 !== 3'd2) begin errors++; $display("FAIL rstf_queue got %0d exp 2", cnt0); end
            end
        end
        #2 rstN = 1'b0;
        #1;
        checks++; if (ser0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 3'd0 || if0.dataReady !== 1'b1) begin
            errors++; $display("FAIL rstf_async got ser=%b busy=%b cnt=%0d rdy=%b exp 1 0 0 1", ser0, busy0, cnt0, if0.dataReady);
        end
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(4);
            checks++;
            if (ser0 !== 1'b1 || busy0 !== 1'b0) begin
                errors++; $display("FAIL rstf_after %0d got ser=%b busy=%b exp 1 0", i, ser0, busy0);
            end
        end
    endtask

    initial begin
        rstN = 1'b0; clkEn = 1'b0;
        if0.inputData = '0; if0.dataValid = 1'b0;
        if1.inputData = '0; if1.dataValid = 1'b0;
        if2.inputData = '0; if2.dataValid = 1'b0;
        test_reset;
        test_frame_8n1;
        test_parity;
        test_fifo_full;
        test_back_to_back;
        test_midframe_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
